// File: rtl/cam_match_if.sv
// Bus bundle for the CAM storage/compare stage: insert, delete, search,
// flush control and the status/result signals returned by the array.
interface cam_match_if #(
  parameter int DEPTH     = 4,
  parameter int KEY_WIDTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  // insert channel
  logic                 ins_en;
  logic [KEY_WIDTH-1:0] ins_key;
  logic                 ins_ready;
  logic                 ins_done;
  logic [AW-1:0]        ins_addr;

  // delete channel
  logic                 del_en;
  logic [AW-1:0]        del_addr;

  // flush sweep request
  logic                 flush;

  // search channel
  logic                 search_en;
  logic [KEY_WIDTH-1:0] search_key;
  logic [DEPTH-1:0]     match_lines;
  logic                 match_valid;

  // status
  logic [OW-1:0]        occupancy;
  logic                 full;
  logic                 empty;
  logic                 busy;

  modport master (
    output ins_en, ins_key, del_en, del_addr, flush, search_en, search_key,
    input  ins_ready, ins_done, ins_addr, match_lines, match_valid,
           occupancy, full, empty, busy
  );

  modport slave (
    input  ins_en, ins_key, del_en, del_addr, flush, search_en, search_key,
    output ins_ready, ins_done, ins_addr, match_lines, match_valid,
           occupancy, full, empty, busy
  );
endinterface

// File: rtl/cam_match_array.sv
// CAM storage-and-compare stage. Holds DEPTH keys with per-entry valid bits,
// inserts into the lowest free entry, deletes by address, sweeps the array
// clean on flush, and registers a parallel match-line vector per search.
// All state updates read the pre-edge contents, so a search, insert and
// delete issued together all see the array as it was before that edge.
module cam_match_array #(
  parameter int DEPTH     = 4,
  parameter int KEY_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  cam_match_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]           state_reg;
  logic [DEPTH-1:0]     valid_reg;
  logic [DEPTH-1:0]     valid_next;
  logic [KEY_WIDTH-1:0] key_mem [DEPTH];
  logic [OW-1:0]        occupancy_reg;
  logic [OW-1:0]        occupancy_next;
  logic [AW-1:0]        flush_idx_reg;
  logic [DEPTH-1:0]     match_lines_reg;
  logic                 match_valid_reg;
  logic                 ins_done_reg;
  logic [AW-1:0]        ins_addr_reg;

  logic                 idle;
  logic                 full_w;
  logic                 empty_w;
  logic                 ready_w;
  logic                 ins_acc;
  logic                 del_eff;
  logic                 flush_clr;
  logic                 search_acc;
  logic [AW-1:0]        free_idx;
  logic [DEPTH-1:0]     hit;

  // Status is derived from registered state only, so a delete issued in the
  // same cycle cannot unblock an insert into a full array.
  assign idle       = (state_reg == ST_IDLE);
  assign full_w     = (occupancy_reg == OW'(DEPTH));
  assign empty_w    = (occupancy_reg == '0);
  assign ready_w    = idle && !full_w;
  assign ins_acc    = ready_w && bus.ins_en;
  assign search_acc = idle && bus.search_en;
  // A delete only counts if it hits a currently valid entry.
  assign del_eff    = idle && bus.del_en && valid_reg[bus.del_addr];
  // During the sweep, the occupancy drops only when the swept entry was live.
  assign flush_clr  = !idle && valid_reg[flush_idx_reg];

  // Parallel compare of every stored key against the search key.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit[gi] = valid_reg[gi] && (key_mem[gi] == bus.search_key);
    end
  endgenerate

  // Lowest-index free entry, taken from the pre-delete valid bits.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = AW'(i);
    end
  end

  // Next valid vector: delete clears first, insert sets; the sweep clears one.
  always_comb begin
    valid_next = valid_reg;
    if (idle) begin
      if (bus.del_en) valid_next[bus.del_addr] = 1'b0;
      if (ins_acc)    valid_next[free_idx]     = 1'b1;
    end else begin
      valid_next[flush_idx_reg] = 1'b0;
    end
  end

  // Occupancy tracks the valid-bit population incrementally.
  always_comb begin
    occupancy_next = occupancy_reg + OW'(ins_acc) - OW'(del_eff || flush_clr);
  end

  // Control state, valid bits, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      valid_reg       <= '0;
      occupancy_reg   <= '0;
      flush_idx_reg   <= '0;
      match_lines_reg <= '0;
      match_valid_reg <= 1'b0;
      ins_done_reg    <= 1'b0;
      ins_addr_reg    <= '0;
    end else begin
      valid_reg       <= valid_next;
      occupancy_reg   <= occupancy_next;
      ins_done_reg    <= ins_acc;
      match_valid_reg <= search_acc;
      match_lines_reg <= search_acc ? hit : '0;
      if (ins_acc) ins_addr_reg <= free_idx;
      if (idle) begin
        if (bus.flush) begin
          state_reg     <= ST_FLUSH;
          flush_idx_reg <= '0;
        end
      end else if (flush_idx_reg == AW'(DEPTH - 1)) begin
        state_reg     <= ST_IDLE;
        flush_idx_reg <= '0;
      end else begin
        flush_idx_reg <= flush_idx_reg + 1'b1;
      end
    end
  end

  // Key storage is never reset; validity alone decides whether a key counts.
  always_ff @(posedge clk) begin
    if (rst_n && ins_acc) key_mem[free_idx] <= bus.ins_key;
  end

  assign bus.ins_ready   = ready_w;
  assign bus.ins_done    = ins_done_reg;
  assign bus.ins_addr    = ins_addr_reg;
  assign bus.match_lines = match_lines_reg;
  assign bus.match_valid = match_valid_reg;
  assign bus.occupancy   = occupancy_reg;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.busy        = !idle;
endmodule

// File: tb/tb_cam_match_array.sv
// Self-checking bench for cam_match_array: directed scenario with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the key table.
module tb_cam_match_array;
  localparam int DEPTH = 4;
  localparam int KW    = 32;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cam_match_if #(.DEPTH(DEPTH), .KEY_WIDTH(KW)) bus ();

  cam_match_array #(.DEPTH(DEPTH), .KEY_WIDTH(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  // Model: committed view (m_*/e_*) and the prediction for the next edge (n_*).
  logic [DEPTH-1:0] m_v, n_v;
  logic [KW-1:0]    m_k [DEPTH];
  logic [KW-1:0]    n_k [DEPTH];
  int               m_fp, n_fp;          // sweep position, -1 when not sweeping
  logic             e_done, n_done, e_mv, n_mv;
  logic [AW-1:0]    e_addr, n_addr;
  logic [DEPTH-1:0] e_ml, n_ml;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Predict the array contents and registered outputs after the next edge.
  task automatic predict(input bit rn, input bit ie, input logic [KW-1:0] ik,
                         input bit de, input logic [AW-1:0] da, input bit fl,
                         input bit se, input logic [KW-1:0] sk);
    int free;
    n_v = m_v; n_fp = m_fp; n_done = 1'b0; n_mv = 1'b0; n_ml = '0; n_addr = e_addr;
    for (int i = 0; i < DEPTH; i++) n_k[i] = m_k[i];
    if (!rn) begin
      n_v = '0; n_fp = -1; n_addr = '0;
    end else if (m_fp >= 0) begin
      n_v[m_fp] = 1'b0;
      n_fp = (m_fp == DEPTH - 1) ? -1 : m_fp + 1;
    end else begin
      if (se) begin
        n_mv = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_k[i] == sk) n_ml[i] = 1'b1;
      end
      free = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) free = i;
      if (de) n_v[da] = 1'b0;
      if (ie && free >= 0) begin
        n_v[free] = 1'b1; n_k[free] = ik; n_done = 1'b1; n_addr = AW'(free);
      end
      if (fl) n_fp = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the clock, commit the model.
  task automatic step(input bit rn, input bit ie, input logic [KW-1:0] ik,
                      input bit de, input logic [AW-1:0] da, input bit fl,
                      input bit se, input logic [KW-1:0] sk);
    rst_n = rn;
    bus.ins_en = ie; bus.ins_key = ik; bus.del_en = de; bus.del_addr = da;
    bus.flush = fl; bus.search_en = se; bus.search_key = sk;
    predict(rn, ie, ik, de, da, fl, se, sk);
    @(posedge clk);
    m_v = n_v; m_fp = n_fp; e_done = n_done; e_addr = n_addr; e_mv = n_mv; e_ml = n_ml;
    for (int i = 0; i < DEPTH; i++) m_k[i] = n_k[i];
    #1;
    cmp_on = 1'b1;
  endtask

  task automatic idle_step();
    step(1, 0, '0, 0, '0, 0, 0, '0);
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("match_lines", 64'(bus.match_lines), 64'(e_ml));
      chk("match_valid", 64'(bus.match_valid), 64'(e_mv));
      chk("ins_done",    64'(bus.ins_done),    64'(e_done));
      chk("ins_addr",    64'(bus.ins_addr),    64'(e_addr));
      chk("occupancy",   64'(bus.occupancy),   64'($countones(m_v)));
      chk("full",        64'(bus.full),        64'($countones(m_v) == DEPTH));
      chk("empty",       64'(bus.empty),       64'($countones(m_v) == 0));
      chk("busy",        64'(bus.busy),        64'(m_fp >= 0));
      chk("ins_ready",   64'(bus.ins_ready),   64'(m_fp < 0 && $countones(m_v) < DEPTH));
    end
  end

  initial begin
    logic [KW-1:0] keys [4];
    m_v = '0; m_fp = -1; e_done = 0; e_addr = '0; e_mv = 0; e_ml = '0;
    for (int i = 0; i < DEPTH; i++) m_k[i] = '0;
    keys[0] = 32'hA; keys[1] = 32'hB; keys[2] = 32'hC; keys[3] = 32'hD;

    step(0, 0, '0, 0, '0, 0, 0, '0);
    step(0, 0, '0, 0, '0, 0, 0, '0);
    chk("rst_ready", 64'(bus.ins_ready), 64'd1);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    idle_step();

    // Fill the array; addresses must come out 0..3.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, keys[i], 0, '0, 0, 0, '0);
      chk("fill_done", 64'(bus.ins_done), 64'd1);
      chk("fill_addr", 64'(bus.ins_addr), 64'(i));
    end
    chk("fill_occ", 64'(bus.occupancy), 64'd4);
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_ready", 64'(bus.ins_ready), 64'd0);
    step(1, 1, 32'hE, 0, '0, 0, 0, '0);
    chk("fifth_done", 64'(bus.ins_done), 64'd0);

    step(1, 0, '0, 0, '0, 0, 1, 32'hC);
    chk("srch_c", 64'(bus.match_lines), 64'b0100);
    chk("srch_c_v", 64'(bus.match_valid), 64'd1);
    step(1, 0, '0, 0, '0, 0, 1, 32'hE);
    chk("srch_e", 64'(bus.match_lines), 64'd0);
    chk("srch_e_v", 64'(bus.match_valid), 64'd1);

    // Full: delete 2 + insert 0x5 + search 0xC in one cycle.
    step(1, 1, 32'h5, 1, 2'd2, 0, 1, 32'hC);
    chk("fd_done", 64'(bus.ins_done), 64'd0);
    chk("fd_occ", 64'(bus.occupancy), 64'd3);
    chk("fd_match", 64'(bus.match_lines), 64'b0100);

    step(1, 0, '0, 1, 2'd1, 0, 0, '0);
    step(1, 1, 32'hF, 0, '0, 0, 0, '0);
    chk("reuse_addr", 64'(bus.ins_addr), 64'd1);
    step(1, 0, '0, 1, 2'd2, 0, 0, '0);
    chk("del_inv_occ", 64'(bus.occupancy), 64'd3);

    // Duplicates: clear 0..2, insert 0x7 twice.
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, AW'(i), 0, 0, '0);
    step(1, 1, 32'h7, 0, '0, 0, 0, '0);
    step(1, 1, 32'h7, 0, '0, 0, 0, '0);
    step(1, 0, '0, 0, '0, 0, 1, 32'h7);
    chk("dup_match", 64'(bus.match_lines), 64'b0011);

    // Flush with 3 live entries, searching throughout.
    step(1, 0, '0, 0, '0, 1, 0, '0);
    chk("fl_busy", 64'(bus.busy), 64'd1);
    chk("fl_occ0", 64'(bus.occupancy), 64'd3);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, 32'h7, 0, '0, 0, 1, 32'h7);
      chk("fl_mv", 64'(bus.match_valid), 64'd0);
    end
    chk("fl_end_busy", 64'(bus.busy), 64'd0);
    chk("fl_end_occ", 64'(bus.occupancy), 64'd0);

    // Reset in the middle of a sweep.
    step(1, 1, 32'h1, 0, '0, 0, 0, '0);
    step(1, 1, 32'h2, 0, '0, 0, 0, '0);
    step(1, 0, '0, 0, '0, 1, 0, '0);
    idle_step();
    step(0, 0, '0, 0, '0, 0, 0, '0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_empty", 64'(bus.empty), 64'd1);
    idle_step();

    // Randomized traffic over a small key space so hits and duplicates occur.
    for (int c = 0; c < 3000; c++) begin
      bit rn, ie, de, fl, se;
      rn = ($urandom_range(0, 299) != 0);
      fl = ($urandom_range(0, 59) == 0);
      ie = !fl && ($urandom_range(0, 1) == 1);
      de = !fl && ($urandom_range(0, 2) == 0);
      se = !fl && ($urandom_range(0, 1) == 1);
      step(rn, ie, KW'($urandom_range(0, 7)), de, AW'($urandom_range(0, DEPTH - 1)),
           fl, se, KW'($urandom_range(0, 7)));
    end

    cmp_on = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
